// File: rtl/bullet_engine_pkg.sv
// Shared types and constants for the single-bullet attack engine.
// Pattern entries, FSM states, colour codes and play-area limits live here.
package bullet_pkg;

    localparam int          AREA_MAX    = 200;
    localparam int          GAP_FRAMES  = 30;
    localparam int          HIT_DIST    = 16;
    localparam int          BLUE_DIST   = 58;
    localparam logic [7:0]  DMG         = 8'd4;
    localparam logic [3:0]  BATTLE_CODE = 4'b1001;

    localparam logic [1:0]  C_WHITE = 2'd0;
    localparam logic [1:0]  C_GREEN = 2'd1;
    localparam logic [1:0]  C_BLUE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPAWN = 2'd1,
        MOVE  = 2'd2,
        GAP   = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0]        x;
        logic [7:0]        y;
        logic signed [7:0] dx;
        logic signed [7:0] dy;
        logic [1:0]        color;
    } pattern_t;

    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/bullet_engine_if.sv
// Bundle between the bullet engine, its frame/state/player sources and the renderer.
// master = engine side; slave = environment side. fsm_state exposes the engine FSM for debug.
interface bullet_engine_if;
    logic                  vsync;
    logic [31:0]           state;
    logic [15:0]           playerPos;
    logic [15:0]           bulletPos;
    logic [1:0]            bulletColor;
    logic                  isRender;
    logic [7:0]            damage;
    logic                  heal;
    logic [2:0]            patIdx;
    bullet_pkg::state_t    fsm_state;

    modport master (
        input  vsync, state, playerPos,
        output bulletPos, bulletColor, isRender, damage, heal, patIdx, fsm_state
    );

    modport slave (
        output vsync, state, playerPos,
        input  bulletPos, bulletColor, isRender, damage, heal, patIdx, fsm_state
    );
endinterface

// File: rtl/bullet_pattern_rom.sv
// Fixed 8-entry attack pattern table: start position, per-frame velocity and colour.
module bullet_pattern_rom
    import bullet_pkg::*;
(
    input  logic [2:0] idx,
    output pattern_t   entry
);
    always_comb begin
        entry = '{8'd0, 8'd100, 8'sd4, 8'sd0, C_WHITE};
        case (idx)
            3'd0: entry = '{8'd0,   8'd100,  8'sd4,  8'sd0, C_WHITE};
            3'd1: entry = '{8'd200, 8'd40,  -8'sd3,  8'sd0, C_WHITE};
            3'd2: entry = '{8'd100, 8'd0,    8'sd0,  8'sd2, C_GREEN};
            3'd3: entry = '{8'd0,   8'd100,  8'sd1,  8'sd0, C_BLUE};
            3'd4: entry = '{8'd0,   8'd0,    8'sd3,  8'sd3, C_WHITE};
            3'd5: entry = '{8'd200, 8'd0,   -8'sd3,  8'sd3, C_WHITE};
            3'd6: entry = '{8'd60,  8'd200,  8'sd0, -8'sd4, C_GREEN};
            3'd7: entry = '{8'd140, 8'd200,  8'sd0, -8'sd5, C_WHITE};
            default: ;
        endcase
    end
endmodule

// File: rtl/bullet_engine.sv
// Single-bullet engine: spawns pattern entries, moves them once per frame,
// detects hits against the player heart and emits one-cycle damage/heal pulses.
module bullet_engine
    import bullet_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    bullet_engine_if.master bus
);
    state_t            st, st_next;
    logic              vs_d, tick, en, moved;
    logic [15:0]       prev_pos;
    logic [7:0]        x, y;
    logic signed [7:0] dx, dy;
    logic [1:0]        color;
    logic              blue_hit, is_render, heal_q;
    logic [4:0]        gap;
    logic [2:0]        pat_idx;
    logic [7:0]        damage_q;
    pattern_t          rom_entry;

    logic [7:0] ax, ay;
    logic [9:0] nx, ny;
    logic       out_xy, in_box, in_blue_box;
    logic       do_spawn, do_move, do_despawn, hit_dmg, hit_heal, set_blue, gap_dec;
    logic       unused_bits;

    bullet_pattern_rom u_rom (.idx(pat_idx), .entry(rom_entry));

    assign tick        = bus.vsync & ~vs_d;
    assign en          = (bus.state[31:28] == BATTLE_CODE);
    assign moved       = (bus.playerPos != prev_pos);
    assign unused_bits = ^bus.state[27:0];

    assign ax = abs_diff(x, bus.playerPos[15:8]);
    assign ay = abs_diff(y, bus.playerPos[7:0]);
    // Sign-extended step; bit 9 set means the bullet left through the zero edge.
    assign nx = {2'b00, x} + {{2{dx[7]}}, dx};
    assign ny = {2'b00, y} + {{2{dy[7]}}, dy};
    assign out_xy = nx[9] || (nx > 10'(AREA_MAX)) || ny[9] || (ny > 10'(AREA_MAX));
    assign in_box      = (ax <= 8'(HIT_DIST))  && (ay <= 8'(HIT_DIST));
    assign in_blue_box = (ax <= 8'(BLUE_DIST)) && (ay <= 8'(BLUE_DIST));

    always_comb begin
        st_next    = st;
        do_spawn   = 1'b0;
        do_move    = 1'b0;
        do_despawn = 1'b0;
        hit_dmg    = 1'b0;
        hit_heal   = 1'b0;
        set_blue   = 1'b0;
        gap_dec    = 1'b0;
        if (!en) begin
            st_next = IDLE;
        end else begin
            case (st)
                IDLE: if (tick) st_next = SPAWN;
                SPAWN: begin
                    do_spawn = 1'b1;
                    st_next  = MOVE;
                end
                MOVE: if (tick) begin
                    if (color != C_BLUE && in_box) begin
                        // Hit wins over leaving the area: one pulse, one despawn.
                        do_despawn = 1'b1;
                        hit_heal   = (color == C_GREEN);
                        hit_dmg    = (color != C_GREEN);
                    end else begin
                        if (color == C_BLUE && in_blue_box && moved && !blue_hit) begin
                            hit_dmg  = 1'b1;
                            set_blue = 1'b1;
                        end
                        if (out_xy) do_despawn = 1'b1;
                        else        do_move    = 1'b1;
                    end
                    if (do_despawn) st_next = GAP;
                end
                GAP: if (tick) begin
                    if (gap == 5'd0) st_next = SPAWN;
                    else             gap_dec = 1'b1;
                end
                default: st_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= IDLE;
            vs_d      <= 1'b1;
            prev_pos  <= '0;
            x         <= '0;
            y         <= '0;
            dx        <= '0;
            dy        <= '0;
            color     <= C_WHITE;
            blue_hit  <= 1'b0;
            is_render <= 1'b0;
            gap       <= '0;
            pat_idx   <= '0;
            damage_q  <= '0;
            heal_q    <= 1'b0;
        end else begin
            st       <= st_next;
            vs_d     <= bus.vsync;
            damage_q <= hit_dmg ? DMG : 8'd0;
            heal_q   <= hit_heal;
            if (tick) prev_pos <= bus.playerPos;
            if (!en) begin
                is_render <= 1'b0;
                pat_idx   <= '0;
            end
            if (do_spawn) begin
                x         <= rom_entry.x;
                y         <= rom_entry.y;
                dx        <= rom_entry.dx;
                dy        <= rom_entry.dy;
                color     <= rom_entry.color;
                is_render <= 1'b1;
                blue_hit  <= 1'b0;
            end
            if (set_blue) blue_hit <= 1'b1;
            if (do_move) begin
                x <= nx[7:0];
                y <= ny[7:0];
            end
            if (do_despawn) begin
                is_render <= 1'b0;
                pat_idx   <= pat_idx + 3'd1;
                gap       <= 5'(GAP_FRAMES - 1);
            end
            if (gap_dec) gap <= gap - 5'd1;
        end
    end

    assign bus.bulletPos   = {x, y};
    assign bus.bulletColor = color;
    assign bus.isRender    = is_render;
    assign bus.damage      = damage_q;
    assign bus.heal        = heal_q;
    assign bus.patIdx      = pat_idx;
    assign bus.fsm_state   = st;
endmodule

// File: tb/tb_bullet_engine.sv
// Directed bench for bullet_engine: walks patterns 0..3 through spawn, motion,
// exit, hits, disable and reset, with hand-computed expectations.
module tb_bullet_engine;
    import bullet_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    bullet_engine_if bus ();

    bullet_engine dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pos(input int px, input int py);
        return {8'(px), 8'(py)};
    endfunction

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One vsync pulse spanning exactly one rising edge; returns on the negedge after it.
    task automatic frame();
        @(negedge clk) bus.vsync = 1'b1;
        @(negedge clk) bus.vsync = 1'b0;
    endtask

    task automatic frames(input int n);
        repeat (n) frame();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int blue_hits;
        bus.vsync     = 1'b0;
        bus.state     = 32'h0;
        bus.playerPos = pos(250, 250);
        reset         = 1'b1;
        clocks(2);
        check("rst_pos",    32'(bus.bulletPos),   32'h0);
        check("rst_color",  32'(bus.bulletColor), 32'h0);
        check("rst_render", 32'(bus.isRender),    32'h0);
        check("rst_damage", 32'(bus.damage),      32'h0);
        check("rst_heal",   32'(bus.heal),        32'h0);
        check("rst_pat",    32'(bus.patIdx),      32'h0);
        check("rst_fsm",    32'(bus.fsm_state),   32'(IDLE));
        reset = 1'b0;

        // First spawn and motion of entry 0.
        bus.state = 32'h9000_0000;
        frame();
        check("spawn_fsm", 32'(bus.fsm_state), 32'(SPAWN));
        clocks(1);
        check("spawn_pos",    32'(bus.bulletPos),   32'h0064);
        check("spawn_render", 32'(bus.isRender),    32'h1);
        check("spawn_color",  32'(bus.bulletColor), 32'h0);
        frames(3);
        check("move3_pos", 32'(bus.bulletPos), 32'h0C64);

        // Run to the right edge and out.
        frames(47);
        check("edge_pos",    32'(bus.bulletPos), pos(200, 100));
        check("edge_render", 32'(bus.isRender),  32'h1);
        frame();
        check("exit_render", 32'(bus.isRender),  32'h0);
        check("exit_pat",    32'(bus.patIdx),    32'h1);
        check("exit_fsm",    32'(bus.fsm_state), 32'(GAP));
        frames(29);
        check("gap29_render", 32'(bus.isRender),  32'h0);
        check("gap29_fsm",    32'(bus.fsm_state), 32'(GAP));
        frame();
        check("gap30_fsm", 32'(bus.fsm_state), 32'(SPAWN));
        clocks(1);
        check("e1_pos",    32'(bus.bulletPos), pos(200, 40));
        check("e1_render", 32'(bus.isRender),  32'h1);

        // Leave battle mid-MOVE, then come back.
        bus.state = 32'h1000_0000;
        clocks(1);
        check("dis_render", 32'(bus.isRender),  32'h0);
        check("dis_pat",    32'(bus.patIdx),    32'h0);
        check("dis_fsm",    32'(bus.fsm_state), 32'(IDLE));
        bus.state = 32'h9000_0000;
        frame();
        clocks(1);
        check("reen_pos",    32'(bus.bulletPos), 32'h0064);
        check("reen_render", 32'(bus.isRender),  32'h1);

        // White hit: box edge at |dx| = 16 on the second tick.
        bus.playerPos = pos(20, 100);
        frame();
        check("w_t1_pos",    32'(bus.bulletPos), 32'h0464);
        check("w_t1_damage", 32'(bus.damage),    32'h0);
        frame();
        check("w_t2_damage", 32'(bus.damage),   32'h4);
        check("w_t2_render", 32'(bus.isRender), 32'h0);
        check("w_t2_pat",    32'(bus.patIdx),   32'h1);
        clocks(1);
        check("w_pulse_end", 32'(bus.damage), 32'h0);

        // Entry 1 spawns on top of the heart: hit on the first tick.
        bus.playerPos = pos(200, 40);
        frames(30);
        clocks(1);
        check("e1b_pos", 32'(bus.bulletPos), pos(200, 40));
        frame();
        check("e1b_damage", 32'(bus.damage), 32'h4);
        check("e1b_pat",    32'(bus.patIdx), 32'h2);

        // Green entry 2 heals.
        bus.playerPos = pos(100, 10);
        frames(30);
        clocks(1);
        check("g_color", 32'(bus.bulletColor), 32'h1);
        check("g_pos",   32'(bus.bulletPos),   pos(100, 0));
        frame();
        check("g_heal",   32'(bus.heal),     32'h1);
        check("g_damage", 32'(bus.damage),   32'h0);
        check("g_render", 32'(bus.isRender), 32'h0);
        check("g_pat",    32'(bus.patIdx),   32'h3);
        clocks(1);
        check("g_heal_end", 32'(bus.heal), 32'h0);

        // Blue entry 3: only hurts while the heart moves, and only once.
        bus.playerPos = pos(40, 100);
        frames(30);
        clocks(1);
        check("b_color", 32'(bus.bulletColor), 32'h2);
        check("b_pos",   32'(bus.bulletPos),   32'h0064);
        for (int i = 0; i < 5; i++) begin
            frame();
            check($sformatf("b_still_%0d", i), 32'(bus.damage), 32'h0);
        end
        blue_hits = 0;
        for (int i = 0; i < 5; i++) begin
            bus.playerPos = pos(41 + i, 100);
            frame();
            if (bus.damage == 8'd4) blue_hits++;
        end
        check("b_hits",   32'(blue_hits),    32'h1);
        check("b_pos10",  32'(bus.bulletPos), pos(10, 100));
        check("b_render", 32'(bus.isRender),  32'h1);

        // Reach GAP, then reset with vsync held high.
        bus.state = 32'h1000_0000;
        clocks(1);
        bus.state = 32'h9000_0000;
        bus.playerPos = pos(20, 100);
        frame();
        clocks(1);
        frames(2);
        check("pre_rst_fsm", 32'(bus.fsm_state), 32'(GAP));
        check("pre_rst_pat", 32'(bus.patIdx),    32'h1);
        bus.vsync = 1'b1;
        reset     = 1'b1;
        clocks(1);
        check("grst_pos",    32'(bus.bulletPos),   32'h0);
        check("grst_color",  32'(bus.bulletColor), 32'h0);
        check("grst_render", 32'(bus.isRender),    32'h0);
        check("grst_damage", 32'(bus.damage),      32'h0);
        check("grst_heal",   32'(bus.heal),        32'h0);
        check("grst_pat",    32'(bus.patIdx),      32'h0);
        check("grst_fsm",    32'(bus.fsm_state),   32'(IDLE));
        reset = 1'b0;
        clocks(5);
        check("notick_fsm",    32'(bus.fsm_state), 32'(IDLE));
        check("notick_render", 32'(bus.isRender),  32'h0);
        bus.vsync = 1'b0;
        clocks(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
